timer_counter: RTL and testbench
================================

# timer_counter

Memory-mapped programmable down-counter on the system bus, directly downstream of the address bridge. It occupies one 12-byte window (Timer0 at 0x7f00–0x7f0b, Timer1 at 0x7f10–0x7f1b, same block instantiated twice), takes word writes gated by the bridge's per-timer write enable, and returns read data to the bridge's read mux. On terminal count it raises an interrupt line that feeds one bit of the CPU's HWInt vector.

## Interface
- No parameters.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- addr  in  30  word address bits [31:2]; only addr[3:2] decoded.
- we  in  1  write strobe from bridge (already range-qualified).
- din  in  32  write data.
- dout  out  32  read data, combinational from addr[3:2].
- irq  out  1  interrupt request, level.

## Operation
- Registers by addr[3:2]: 00 CTRL (RW), 01 PRESET (RW), 10 COUNT (RO, writes ignored), 11 reads 0, writes ignored.
- CTRL bits: [0] EN, [2:1] MODE, [3] IM (irq mask); bits [31:4] read 0. MODE 00 one-shot, 01 auto-reload, 10/11 behave as 00.
- Internal irq_flag; irq = IM & irq_flag.
- FSM states IDLE, LOAD, CNT, INT:
  - IDLE: EN=1 -> LOAD; else stay.
  - LOAD: COUNT <= PRESET; -> CNT.
  - CNT: EN=0 -> IDLE, COUNT holds. EN=1 and COUNT>1 -> COUNT-1, stay. EN=1 and COUNT<=1 -> COUNT <= 0, irq_flag <= 1, -> INT.
  - INT, one-shot: EN <= 0, -> IDLE; irq_flag stays 1. INT, auto-reload: irq_flag <= 0, -> LOAD.
- Any write to CTRL clears irq_flag.
- Same-edge conflict: a software CTRL write overrides the FSM's EN clear in INT.
- A PRESET write does not change a running COUNT; it takes effect at the next LOAD.
- Unsigned 32-bit arithmetic. PRESET=0 behaves as PRESET=1.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, state IDLE, irq_flag=0, irq=0. dout follows the registers (0 for every address).
- Reset overrides any same-cycle write and aborts counting mid-operation.
- Writes commit at the clk edge where we=1. Reads are same-cycle combinational, so a read in the same cycle as a write returns the old value.
- Edge numbering: the write setting EN commits at edge E0. LOAD is entered at E1. COUNT=PRESET (P) at E2. INT is entered and irq_flag set at E(P+2) for P>=1.
- One-shot: irq stays high until a CTRL write.
- Auto-reload: irq is high exactly one cycle (the INT cycle). The period is P+2 cycles (CNT P cycles, INT 1 cycle, LOAD 1 cycle).

## Configuration
- TC_AUTO_RELOAD_EN defined: MODE 01 is auto-reload as above.
- Not defined: MODE bits are stored and read back but ignored, and every mode behaves as one-shot.

## Structure
- Shared package tc_pkg holds:
  - state enum (IDLE/LOAD/CNT/INT, 2 bits);
  - register offsets (CTRL=0, PRESET=1, COUNT=2, word index);
  - CTRL bit positions (EN=0, MODE=2:1, IM=3);
  - mode encodings.
- Single flat module; no sub-module is warranted.

## Test plan
- Reset, then read addr[3:2]=00/01/10/11 -> all 0, irq=0.
- PRESET=5, CTRL=0x9 (IM=1, EN=1, one-shot) -> COUNT reads 5,4,3,2,1 then 0; irq rises 7 edges after the CTRL write and holds; CTRL EN reads 0; a CTRL write drops irq.
- PRESET=3, CTRL=0xB (auto-reload) -> irq one-cycle pulse every 5 cycles, repeating for at least 3 periods. With the macro undefined, a single held pulse.
- Mid-count CTRL write of 0x8 (EN=0) at COUNT=4 -> COUNT holds 4, no irq. Re-enable -> reloads PRESET.
- IM=0 run to terminal -> irq stays 0; then writing CTRL=0x8 (IM=1, EN=0) clears the flag, so irq stays 0. Write to COUNT with 0x1234 -> COUNT unchanged.
- Assert reset while in CNT with COUNT=10 -> next edge: all registers 0, state IDLE, irq 0.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared types and constants for the memory-mapped down-counter timer.
// TC_AUTO_RELOAD_EN enables auto-reload mode; without it every mode runs one-shot.
package tc_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StCnt  = 2'd2,
    StInt  = 2'd3
  } tc_state_e;

  // Word index within the window, taken from addr[3:2].
  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegPreset = 2'd1;
  localparam logic [1:0] RegCount  = 2'd2;

  localparam int unsigned CtrlEnBit   = 0;
  localparam int unsigned CtrlModeLsb = 1;
  localparam int unsigned CtrlModeMsb = 2;
  localparam int unsigned CtrlImBit   = 3;
  localparam int unsigned CtrlWidth   = CtrlImBit + 1;

  // Reserved encodings 10/11 run as one-shot.
  typedef enum logic [1:0] {
    ModeOneShot    = 2'b00,
    ModeAutoReload = 2'b01,
    ModeRsvd2      = 2'b10,
    ModeRsvd3      = 2'b11
  } tc_mode_e;

  function automatic logic [31:0] ctrl_rdata(input logic [CtrlWidth-1:0] ctrl);
    return {{(32 - CtrlWidth){1'b0}}, ctrl};
  endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Bus-side port bundle of the timer: bridge drives address/write, timer returns data and irq.
interface timer_counter_if;
  logic [29:0] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  modport master (output addr, output we, output din, input dout, input irq);
  modport slave  (input addr, input we, input din, output dout, output irq);
endinterface

// File: rtl/timer_counter.sv
// Programmable 32-bit down-counter with CTRL/PRESET/COUNT registers and a level interrupt.
// Auto-reload (MODE 01) exists only when TC_AUTO_RELOAD_EN is defined.
module timer_counter
  import tc_pkg::*;
(
  input logic            clk,
  input logic            reset,
  timer_counter_if.slave bus
);

  logic [CtrlWidth-1:0] ctrl_q;
  logic [31:0]          preset_q;
  logic [31:0]          count_q;
  logic                 irq_flag_q;
  tc_state_e            state_q;
  logic                 auto_reload;
  logic                 unused_addr;

`ifdef TC_AUTO_RELOAD_EN
  assign auto_reload = (tc_mode_e'(ctrl_q[CtrlModeMsb:CtrlModeLsb]) == ModeAutoReload);
`else
  assign auto_reload = 1'b0;
`endif

  // Only addr[3:2] is decoded; the bridge has already range-qualified the strobe.
  assign unused_addr = ^bus.addr[29:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
      state_q    <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ctrl_q[CtrlEnBit]) state_q <= StLoad;
        end
        StLoad: begin
          count_q <= preset_q;
          state_q <= StCnt;
        end
        StCnt: begin
          if (!ctrl_q[CtrlEnBit]) begin
            state_q <= StIdle;
          end else if (count_q > 32'd1) begin
            count_q <= count_q - 32'd1;
          end else begin
            // count<=1 also covers PRESET=0, which therefore behaves as PRESET=1
            count_q    <= '0;
            irq_flag_q <= 1'b1;
            state_q    <= StInt;
          end
        end
        StInt: begin
          if (auto_reload) begin
            irq_flag_q <= 1'b0;
            state_q    <= StLoad;
          end else begin
            ctrl_q[CtrlEnBit] <= 1'b0;
            state_q           <= StIdle;
          end
        end
      endcase

      // Software writes come last so a CTRL write wins over the EN clear in StInt.
      if (bus.we) begin
        case (bus.addr[1:0])
          RegCtrl: begin
            ctrl_q     <= bus.din[CtrlWidth-1:0];
            irq_flag_q <= 1'b0;
          end
          RegPreset: preset_q <= bus.din;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.dout = '0;
    case (bus.addr[1:0])
      RegCtrl:   bus.dout = ctrl_rdata(ctrl_q);
      RegPreset: bus.dout = preset_q;
      RegCount:  bus.dout = count_q;
      default:   bus.dout = '0;
    endcase
  end

  assign bus.irq = ctrl_q[CtrlImBit] & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a run/age based reference model.
module tb_timer_counter;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  timer_counter_if bus ();

  timer_counter dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a run is a sequence of ages; age 0 is the load cycle, ages 1..lim count,
  // age lim+1 is the terminal cycle. COUNT at age a is snapshot-(a-1).
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_flag;
  bit          m_run;
  longint      m_age;
  logic [31:0] m_snap;
  bit          m_valid;

  initial m_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [3:0]  n_ctrl;
    logic [31:0] n_preset;
    logic [31:0] n_count;
    logic        n_flag;
    bit          n_run;
    longint      n_age;
    logic [31:0] n_snap;
    longint      lim;
    bit          auto;
    if (reset) begin
      m_ctrl   = '0;
      m_preset = '0;
      m_count  = '0;
      m_flag   = 1'b0;
      m_run    = 1'b0;
      m_age    = 0;
      m_snap   = '0;
      m_valid  = 1'b1;
      return;
    end
    n_ctrl   = m_ctrl;
    n_preset = m_preset;
    n_count  = m_count;
    n_flag   = m_flag;
    n_run    = m_run;
    n_age    = m_age;
    n_snap   = m_snap;
`ifdef TC_AUTO_RELOAD_EN
    auto = (m_ctrl[2:1] == 2'b01);
`else
    auto = 1'b0;
`endif
    lim = (m_snap == 0) ? 64'd1 : longint'(m_snap);
    if (!m_run) begin
      if (m_ctrl[0]) begin
        n_run = 1'b1;
        n_age = 0;
      end
    end else if (m_age == 0) begin
      n_snap  = m_preset;
      n_count = m_preset;
      n_age   = 1;
    end else if (m_age <= lim) begin
      if (!m_ctrl[0]) begin
        n_run = 1'b0;
      end else if (m_age == lim) begin
        n_count = '0;
        n_flag  = 1'b1;
        n_age   = m_age + 1;
      end else begin
        n_count = m_snap - 32'(m_age);
        n_age   = m_age + 1;
      end
    end else begin
      if (auto) begin
        n_flag = 1'b0;
        n_age  = 0;
      end else begin
        n_ctrl[0] = 1'b0;
        n_run     = 1'b0;
      end
    end
    if (bus.we) begin
      if (bus.addr[1:0] == 2'd0) begin
        n_ctrl = bus.din[3:0];
        n_flag = 1'b0;
      end else if (bus.addr[1:0] == 2'd1) begin
        n_preset = bus.din;
      end
    end
    m_ctrl   = n_ctrl;
    m_preset = n_preset;
    m_count  = n_count;
    m_flag   = n_flag;
    m_run    = n_run;
    m_age    = n_age;
    m_snap   = n_snap;
  endtask

  task automatic model_run();
    forever begin
      @(posedge clk);
      model_step();
    end
  endtask

  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        case (bus.addr[1:0])
          2'd0:    e = {28'h0, m_ctrl};
          2'd1:    e = m_preset;
          2'd2:    e = m_count;
          default: e = '0;
        endcase
        chk("dout_vs_model", bus.dout, e);
        chk("irq_vs_model", {31'h0, bus.irq}, {31'h0, m_ctrl[3] & m_flag});
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    #1;
    bus.addr = {28'h0, a};
    bus.din  = d;
    bus.we   = 1'b1;
    cyc();
    bus.we   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    #1;
    bus.addr = {28'h0, a};
    @(negedge clk);
    v = bus.dout;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] r;
    bit          hit;
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    bus.addr = '0;
    bus.we   = 1'b0;
    bus.din  = '0;
    fork
      model_run();
      monitor();
    join_none
    cyc();
    cyc();
    reset = 1'b0;

    // Reset state
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      chk("reset_reg", v, 32'h0);
    end
    chk("reset_irq", {31'h0, bus.irq}, 32'h0);

    // One-shot, PRESET=5: COUNT 5..1 then 0, irq at the 7th edge after the CTRL write
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 7; k++) begin
      cyc();
      rd(2'd2, v);
      chk("oneshot_count", v, (k < 2) ? 32'd0 : 32'(7 - k));
      chk("oneshot_irq", {31'h0, bus.irq}, (k == 7) ? 32'd1 : 32'd0);
    end
    cyc();
    rd(2'd0, v);
    chk("oneshot_en_cleared", v, 32'h8);
    chk("oneshot_irq_held", {31'h0, bus.irq}, 32'd1);
    wr(2'd0, 32'h8);
    rd(2'd0, v);
    chk("ctrl_write_drops_irq", {31'h0, bus.irq}, 32'd0);

    // PRESET=3, MODE=01: pulse every 5 cycles with auto-reload, a held level without it
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 21; k++) begin
      cyc();
      rd(2'd3, v);
`ifdef TC_AUTO_RELOAD_EN
      chk("auto_irq", {31'h0, bus.irq}, (k >= 5 && (k - 5) % 5 == 0) ? 32'd1 : 32'd0);
`else
      chk("auto_irq", {31'h0, bus.irq}, (k >= 5) ? 32'd1 : 32'd0);
`endif
    end
    wr(2'd0, 32'h0);
    cyc();
    cyc();

    // Mid-count disable at COUNT=4 holds the value; re-enable reloads PRESET
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      rd(2'd2, v);
      if (v == 32'd5) hit = 1'b1;
      else cyc();
    end
    chk("wait_count5", v, 32'd5);
    wr(2'd0, 32'h8);
    for (int k = 0; k < 3; k++) begin
      cyc();
      rd(2'd2, v);
      chk("disabled_count_holds", v, 32'd4);
      chk("disabled_no_irq", {31'h0, bus.irq}, 32'd0);
    end
    wr(2'd0, 32'h9);
    cyc();
    cyc();
    rd(2'd2, v);
    chk("reenable_reload", v, 32'd10);
    wr(2'd0, 32'h0);
    cyc();
    cyc();

    // IM=0 run to terminal, then IM=1 with EN=0: flag was cleared by the write
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    for (int k = 0; k < 6; k++) begin
      cyc();
      rd(2'd0, v);
      chk("masked_irq", {31'h0, bus.irq}, 32'd0);
    end
    wr(2'd0, 32'h8);
    rd(2'd0, v);
    chk("unmask_after_clear_irq", {31'h0, bus.irq}, 32'd0);
    chk("unmask_ctrl", v, 32'h8);
    wr(2'd2, 32'h1234);
    rd(2'd2, v);
    chk("count_readonly", v, 32'd0);

    // Reset mid-count at COUNT=10, with a competing CTRL write on the same edge
    wr(2'd1, 32'd20);
    wr(2'd0, 32'h9);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      rd(2'd2, v);
      if (v == 32'd10) hit = 1'b1;
      else cyc();
    end
    chk("wait_count10", v, 32'd10);
    #1;
    reset    = 1'b1;
    bus.addr = '0;
    bus.din  = 32'h9;
    bus.we   = 1'b1;
    cyc();
    reset  = 1'b0;
    bus.we = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      chk("midrun_reset_reg", v, 32'h0);
      chk("midrun_reset_irq", {31'h0, bus.irq}, 32'd0);
    end

    // Randomized traffic, checked by the monitor against the model
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 499) == 0);
      bus.we   = ($urandom_range(0, 7) == 0);
      bus.addr = 30'($urandom);
      if (bus.addr[1:0] == 2'd1) begin
        bus.din = 32'($urandom_range(0, 6));
      end else begin
        r       = $urandom;
        r[0]    = ($urandom_range(0, 3) != 0);
        bus.din = r;
      end
      cyc();
    end
    reset  = 1'b0;
    bus.we = 1'b0;
    cyc();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
